// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock-level control path: level width,
// reset level and the arbiter FSM state encoding.
package clk_ctrl_pkg;

  localparam int LVL_W = 4;
  localparam logic [LVL_W-1:0] DEFAULT_LVL = 4'd0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // True in every state where the arbiter is working on a request.
  function automatic logic st_is_busy(input logic [1:0] st);
    return (st == ST_APPLY) || (st == ST_SETTLE);
  endfunction

endpackage

// File: rtl/clk_level_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit found when
// searching upward from Ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  output logic [IDX_W-1:0]   Idx,
  output logic               Valid
);

  // Scan every offset from the pointer and keep the first hit.
  always_comb begin
    int               cand_int;
    logic [IDX_W-1:0] cand;
    Idx   = '0;
    Valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = int'(Ptr) + k;
      if (cand_int >= NUM_REQ) begin
        cand_int = cand_int - NUM_REQ;
      end else begin
        cand_int = cand_int;
      end
      cand = cand_int[IDX_W-1:0];
      if (!Valid && Req[cand]) begin
        Valid = 1'b1;
        Idx   = cand;
      end else begin
        Valid = Valid;
      end
    end
  end

endmodule

// File: rtl/clk_level_arbiter.sv
// Round-robin arbiter that hands a divider level from one of NUM_REQ
// requesters to the clock divider, then holds off for SETTLE_CYC cycles
// whenever the level actually changed.
module clk_level_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int SETTLE_CYC = 4,
  parameter logic [clk_ctrl_pkg::LVL_W-1:0] DEFAULT_LVL = clk_ctrl_pkg::DEFAULT_LVL
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic [NUM_REQ-1:0]                    Req,
  input  logic [clk_ctrl_pkg::LVL_W*NUM_REQ-1:0] ReqLvl,
  output logic [NUM_REQ-1:0]                    Grant,
  output logic [clk_ctrl_pkg::LVL_W-1:0]        LevelOut,
  output logic                                  Busy
);
  import clk_ctrl_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] SET_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               chg_q, chg_d;      // latched level differs from old LevelOut
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [LVL_W-1:0]   pick_lvl;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .Req   (Req),
    .Ptr   (ptr_q),
    .Idx   (pick_idx),
    .Valid (pick_valid)
  );

  assign pick_lvl = ReqLvl[int'(pick_idx)*LVL_W +: LVL_W];

  // Next-state logic for the IDLE/APPLY/SETTLE sequence and all outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    chg_d   = chg_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    level_d = level_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_APPLY;
          idx_d   = pick_idx;
          lvl_d   = pick_lvl;
          chg_d   = (pick_lvl != level_q);
          level_d = pick_lvl;
          grant_d = NUM_REQ'(1) << pick_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (idx_q == LAST_IDX) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + IDX_W'(1);
        end
        if (chg_q) begin
          state_d = ST_SETTLE;
          cnt_d   = SET_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = st_is_busy(state_d);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      lvl_q   <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= 8'd0;
      grant_q <= '0;
      level_q <= DEFAULT_LVL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign Grant    = grant_q;
  assign LevelOut = level_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_clk_level_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a transaction-level model (each service = 1 grant cycle plus an
// optional SETTLE_CYC hold-off when the level changes).
module tb_clk_level_arbiter;

  localparam int N = 3;
  localparam int S = 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] Req = '0;
  logic [4*N-1:0] ReqLvl = '0;
  logic [N-1:0] Grant;
  logic [3:0]   LevelOut;
  logic         Busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int           m_left;
  int           m_ptr;
  logic [3:0]   m_lvl;
  logic [N-1:0] m_grant;

  clk_level_arbiter #(.NUM_REQ(N), .SETTLE_CYC(S), .DEFAULT_LVL(4'd0)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ReqLvl(ReqLvl),
    .Grant(Grant), .LevelOut(LevelOut), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_left = 0; m_ptr = 0; m_lvl = 4'd0; m_grant = '0;
  endtask

  // One clock edge of the model: a free arbiter serves the first active
  // requester at or after the pointer and stays busy for its service time.
  task automatic model_edge();
    int w;
    logic [3:0] nl;
    m_grant = '0;
    if (m_left > 0) begin
      m_left--;
    end else if (Req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && Req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      nl = ReqLvl[w*4 +: 4];
      m_grant[w] = 1'b1;
      m_left = (nl == m_lvl) ? 1 : 1 + S;
      m_lvl = nl;
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst) model_reset(); else model_edge();
    @(negedge Clk);
  endtask

  task automatic drain();
    Req = '0;
    repeat (S + 3) tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req = 3'b111; ReqLvl = {4'h7, 4'h5, 4'h3};
    repeat (2) tick();
    n_checks++; if (Grant !== 3'b000) $display("FAIL rst_grant: got %b want 000", Grant); else n_pass++;
    n_checks++; if (LevelOut !== 4'h0) $display("FAIL rst_level: got %h want 0", LevelOut); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
    Rst = 1'b0;
    tick();
    n_checks++; if (Grant !== 3'b001) $display("FAIL rst_first_grant: got %b want 001", Grant); else n_pass++;
    n_checks++; if (LevelOut !== 4'h3) $display("FAIL rst_first_level: got %h want 3", LevelOut); else n_pass++;
    n_checks++; if (Busy !== 1'b1) $display("FAIL rst_first_busy: got %b want 1", Busy); else n_pass++;
    drain();
  endtask

  task automatic test_single();
    int busy_cnt;
    ReqLvl = {4'h0, 4'hA, 4'h0}; Req = 3'b010;
    tick();
    Req = '0;
    n_checks++; if (Grant !== 3'b010) $display("FAIL single_grant: got %b want 010", Grant); else n_pass++;
    n_checks++; if (LevelOut !== 4'hA) $display("FAIL single_level: got %h want a", LevelOut); else n_pass++;
    busy_cnt = int'(Busy);
    for (int i = 0; i < S + 4; i++) begin
      tick();
      busy_cnt += int'(Busy);
      n_checks++; if (Grant !== m_grant) $display("FAIL single_nogrant: got %b want %b", Grant, m_grant); else n_pass++;
      n_checks++; if (LevelOut !== 4'hA) $display("FAIL single_level_hold: got %h want a", LevelOut); else n_pass++;
    end
    n_checks++; if (busy_cnt != S + 1) $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, S + 1); else n_pass++;
  endtask

  task automatic test_same_level();
    int busy_cnt;
    ReqLvl = {4'h0, 4'h0, m_lvl}; Req = 3'b001;
    tick();
    Req = '0;
    n_checks++; if (Grant !== 3'b001) $display("FAIL same_grant: got %b want 001", Grant); else n_pass++;
    busy_cnt = int'(Busy);
    repeat (S + 2) begin
      tick();
      busy_cnt += int'(Busy);
    end
    n_checks++; if (busy_cnt != 1) $display("FAIL same_busy_len: got %0d want 1", busy_cnt); else n_pass++;
    n_checks++; if (LevelOut !== m_lvl) $display("FAIL same_level: got %h want %h", LevelOut, m_lvl); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_seq [4];
    logic [N-1:0] prev_g;
    int got;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    Rst = 1'b1; tick(); Rst = 1'b0;
    ReqLvl = {4'h9, 4'h5, 4'h2}; Req = 3'b111;
    got = 0; prev_g = '0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      tick();
      n_checks++; if (Grant !== m_grant) $display("FAIL fair_model: got %b want %b", Grant, m_grant); else n_pass++;
      if (Grant != '0) begin
        n_checks++; if (Grant !== exp_seq[got]) $display("FAIL fair_order: got %b want %b", Grant, exp_seq[got]); else n_pass++;
        n_checks++; if (prev_g !== '0) $display("FAIL fair_b2b: prev %b want 000", prev_g); else n_pass++;
        got++;
      end
      prev_g = Grant;
    end
    n_checks++; if (got != 4) $display("FAIL fair_count: got %0d want 4", got); else n_pass++;
    drain();
  endtask

  task automatic test_ignored();
    int g2;
    g2 = 0;
    ReqLvl = {4'h0, 4'h0, m_lvl ^ 4'h5}; Req = 3'b001;
    tick();                   // APPLY
    Req = '0;
    tick();                   // SETTLE cycle 1
    Req = 3'b100;
    tick();                   // SETTLE cycle 2
    g2 += int'(Grant[2]);
    tick();                   // SETTLE cycle 3
    g2 += int'(Grant[2]);
    Req = '0;
    for (int i = 0; i < S + 4; i++) begin
      tick();
      g2 += int'(Grant[2]);
      n_checks++; if (Busy !== (m_left > 0)) $display("FAIL ign_busy: got %b want %b", Busy, (m_left > 0)); else n_pass++;
    end
    n_checks++; if (g2 != 0) $display("FAIL ign_grant2: got %0d grants want 0", g2); else n_pass++;
  endtask

  task automatic test_reset_mid_settle();
    ReqLvl = {m_lvl ^ 4'hF, 4'h0, 4'h0}; Req = 3'b100;
    tick();                   // APPLY
    Req = '0;
    n_checks++; if (Grant !== m_grant) $display("FAIL rms_grant: got %b want %b", Grant, m_grant); else n_pass++;
    tick();                   // SETTLE cycle 1
    tick();                   // SETTLE cycle 2
    #2 Rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (LevelOut !== 4'h0) $display("FAIL rms_level: got %h want 0", LevelOut); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL rms_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (Grant !== 3'b000) $display("FAIL rms_grant0: got %b want 000", Grant); else n_pass++;
    tick();
    Rst = 1'b0; Req = 3'b111; ReqLvl = {4'h1, 4'h2, 4'h4};
    tick();
    n_checks++; if (Grant !== 3'b001) $display("FAIL rms_ptr0: got %b want 001", Grant); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      Req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      ReqLvl = (4*N)'($urandom);
      tick();
      n_checks++; if (Grant !== m_grant) $display("FAIL rand_grant c%0d: got %b want %b", c, Grant, m_grant); else n_pass++;
      n_checks++; if (LevelOut !== m_lvl) $display("FAIL rand_level c%0d: got %h want %h", c, LevelOut, m_lvl); else n_pass++;
      n_checks++; if (Busy !== (m_left > 0)) $display("FAIL rand_busy c%0d: got %b want %b", c, Busy, (m_left > 0)); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_same_level();
    test_fairness();
    test_ignored();
    test_reset_mid_settle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
